unified_mem_arbiter: RTL and testbench

// - Shares one single-outstanding memory port between instruction fetch (IF) and data memory (DM, load/store).
// - Sits between the fetch/memory pipeline stages and the unified RAM/bus bridge.
// - Fixed DM priority with a starvation guard for IF.
// - Cancels (drops) in-flight fetch responses on pipeline flush.

---
 rtl/unified_mem_arbiter_pkg.sv | 17 +
 rtl/unified_mem_arbiter_watchdog.sv | 37 +++
 rtl/unified_mem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types for the unified memory arbiter: owner/state enums and the registered request.
package unified_mem_arbiter_pkg;

    localparam int unsigned REGISTER_WIDTH = 32;
    localparam int unsigned STRB_WIDTH     = REGISTER_WIDTH / 8;

    typedef enum logic [1:0] {OWNER_NONE, OWNER_FETCH, OWNER_DATA} mem_owner_e;
    typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT} arb_state_e;

    typedef struct packed {
        logic [REGISTER_WIDTH-1:0] addr;
        logic                      write;
        logic [REGISTER_WIDTH-1:0] wdata;
        logic [STRB_WIDTH-1:0]     wstrb;
    } mem_req_t;

endpackage

// File: rtl/unified_mem_arbiter_watchdog.sv
// Timeout counter for an outstanding memory transaction, plus the sticky error flag.
module unified_mem_arbiter_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic busy,
    input  logic set_error,
    output logic expired,
    output logic timeout_error
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            error_q, error_d;

    always_comb begin
        cnt_d   = busy ? cnt_q + 1'b1 : '0;
        error_d = error_q | set_error;
        expired = busy && (cnt_q == CntLast);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            error_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            error_q <= error_d;
        end
    end

    assign timeout_error = error_q;

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-outstanding memory port between fetch and load/store, DM priority with IF
// starvation guard. Optional timeout watchdog under UNIFIED_MEM_ARB_TIMEOUT_EN.
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
`ifdef UNIFIED_MEM_ARB_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [31:0] if_req_addr,
    output logic        if_resp_valid,
    output logic [31:0] if_resp_data,
    input  logic        dm_req_valid,
    output logic        dm_req_ready,
    input  logic [31:0] dm_req_addr,
    input  logic        dm_req_write,
    input  logic [31:0] dm_req_wdata,
    input  logic [3:0]  dm_req_wstrb,
    output logic        dm_resp_valid,
    output logic [31:0] dm_resp_data,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    output logic        mem_req_write,
    output logic [31:0] mem_req_wdata,
    output logic [3:0]  mem_req_wstrb,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data
`ifdef UNIFIED_MEM_ARB_TIMEOUT_EN
    ,
    output logic        timeout_error
`endif
);

    localparam int unsigned StarveW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);

    arb_state_e       state_q, state_d;
    mem_owner_e       owner_q, owner_d;
    logic             kill_q, kill_d;
    logic [StarveW-1:0] starve_q, starve_d;
    mem_req_t         req_q, req_d;

    logic             if_eff, dm_win;
    logic             resp_fire;
    logic [31:0]      resp_payload;
    logic             timeout_hit;
    logic             timeout_fire;

`ifdef UNIFIED_MEM_ARB_TIMEOUT_EN
    unified_mem_arbiter_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk          (clk),
        .reset_n      (reset_n),
        .busy         (state_q != ARB_IDLE),
        .set_error    (timeout_fire),
        .expired      (timeout_hit),
        .timeout_error(timeout_error)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    // A flushed fetch request is not a contender, so it cannot force the starvation grant.
    assign if_eff = if_req_valid && !flush;
    assign dm_win = dm_req_valid && !(if_eff && (starve_q == StarveMax));

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        kill_d       = kill_q;
        starve_d     = starve_q;
        req_d        = req_q;
        if_req_ready = 1'b0;
        dm_req_ready = 1'b0;
        resp_fire    = 1'b0;
        resp_payload = '0;
        timeout_fire = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (dm_win) begin
                    dm_req_ready = 1'b1;
                    owner_d      = OWNER_DATA;
                    req_d        = '{addr: dm_req_addr, write: dm_req_write,
                                     wdata: dm_req_wdata, wstrb: dm_req_wstrb};
                    state_d      = ARB_ISSUE;
                    // Saturation is implicit: at StarveMax a contending IF always wins.
                    if (if_eff) starve_d = starve_q + 1'b1;
                end else if (if_eff) begin
                    if_req_ready = 1'b1;
                    owner_d      = OWNER_FETCH;
                    req_d        = '{addr: if_req_addr, write: 1'b0, wdata: '0, wstrb: '0};
                    starve_d     = '0;
                    state_d      = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                if (mem_req_ready) state_d = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (mem_resp_valid) begin
                    resp_fire    = 1'b1;
                    resp_payload = mem_resp_data;
                    state_d      = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        // A real response in the expiry cycle takes precedence over the timeout.
        if (state_q != ARB_IDLE && timeout_hit && !resp_fire) begin
            resp_fire    = 1'b1;
            resp_payload = '0;
            timeout_fire = 1'b1;
            state_d      = ARB_IDLE;
        end

        if (state_q != ARB_IDLE && owner_q == OWNER_FETCH && flush) kill_d = 1'b1;

        if (state_d == ARB_IDLE) begin
            owner_d = OWNER_NONE;
            kill_d  = 1'b0;
        end
    end

    always_comb begin
        if_resp_valid = resp_fire && owner_q == OWNER_FETCH && !kill_q && !flush;
        dm_resp_valid = resp_fire && owner_q == OWNER_DATA;
        if_resp_data  = if_resp_valid ? resp_payload : '0;
        dm_resp_data  = dm_resp_valid ? resp_payload : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ARB_IDLE;
            owner_q  <= OWNER_NONE;
            kill_q   <= 1'b0;
            starve_q <= '0;
            req_q    <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            kill_q   <= kill_d;
            starve_q <= starve_d;
            req_q    <= req_d;
        end
    end

    assign mem_req_valid = (state_q == ARB_ISSUE);
    assign mem_req_addr  = req_q.addr;
    assign mem_req_write = req_q.write;
    assign mem_req_wdata = req_q.wdata;
    assign mem_req_wstrb = req_q.wstrb;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter; the timeout scenario runs when
// UNIFIED_MEM_ARB_TIMEOUT_EN is defined.
module tb_unified_mem_arbiter;

    logic        clk;
    logic        reset_n;
    logic        flush;
    logic        if_req_valid;
    logic        if_req_ready;
    logic [31:0] if_req_addr;
    logic        if_resp_valid;
    logic [31:0] if_resp_data;
    logic        dm_req_valid;
    logic        dm_req_ready;
    logic [31:0] dm_req_addr;
    logic        dm_req_write;
    logic [31:0] dm_req_wdata;
    logic [3:0]  dm_req_wstrb;
    logic        dm_resp_valid;
    logic [31:0] dm_resp_data;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_req_write;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
`ifdef UNIFIED_MEM_ARB_TIMEOUT_EN
    logic        timeout_error;
`endif

    int n_total = 0;
    int n_bad   = 0;

    unified_mem_arbiter #(
        .STARVE_LIMIT(4)
`ifdef UNIFIED_MEM_ARB_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(8)
`endif
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .flush         (flush),
        .if_req_valid  (if_req_valid),
        .if_req_ready  (if_req_ready),
        .if_req_addr   (if_req_addr),
        .if_resp_valid (if_resp_valid),
        .if_resp_data  (if_resp_data),
        .dm_req_valid  (dm_req_valid),
        .dm_req_ready  (dm_req_ready),
        .dm_req_addr   (dm_req_addr),
        .dm_req_write  (dm_req_write),
        .dm_req_wdata  (dm_req_wdata),
        .dm_req_wstrb  (dm_req_wstrb),
        .dm_resp_valid (dm_resp_valid),
        .dm_resp_data  (dm_resp_data),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_req_write (mem_req_write),
        .mem_req_wdata (mem_req_wdata),
        .mem_req_wstrb (mem_req_wstrb),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_data (mem_resp_data)
`ifdef UNIFIED_MEM_ARB_TIMEOUT_EN
        ,
        .timeout_error (timeout_error)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From the accept cycle: accept, handshake at once, and present rdata as the response.
    task automatic finish_txn(input logic [31:0] rdata);
        tick();
        if_req_valid  = 1'b0;
        dm_req_valid  = 1'b0;
        dm_req_write  = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = rdata;
        #1;
    endtask

    task automatic end_resp();
        tick();
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=running exp=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        logic exp_if;
        reset_n = 1'b0; flush = 1'b0;
        if_req_valid = 1'b0; if_req_addr = '0;
        dm_req_valid = 1'b0; dm_req_addr = '0; dm_req_write = 1'b0;
        dm_req_wdata = '0; dm_req_wstrb = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
        #2;
        check("rst_req_valid", 32'(mem_req_valid), 32'd0);
        check("rst_req_addr", mem_req_addr, 32'd0);
        check("rst_if_ready", 32'(if_req_ready), 32'd0);
        check("rst_dm_resp", 32'(dm_resp_valid), 32'd0);
        #10 reset_n = 1'b1;
        tick();

        // 1: single fetch, latency profile
        if_req_valid = 1'b1; if_req_addr = 32'h100; #1;
        check("t1_if_ready", 32'(if_req_ready), 32'd1);
        check("t1_dm_ready", 32'(dm_req_ready), 32'd0);
        check("t1_not_issued", 32'(mem_req_valid), 32'd0);
        tick(); if_req_valid = 1'b0; mem_req_ready = 1'b1; #1;
        check("t1_req_valid", 32'(mem_req_valid), 32'd1);
        check("t1_req_addr", mem_req_addr, 32'h100);
        check("t1_req_write", 32'(mem_req_write), 32'd0);
        tick(); mem_req_ready = 1'b0; #1;
        check("t1_wait_valid", 32'(mem_req_valid), 32'd0);
        check("t1_no_resp", 32'(if_resp_valid), 32'd0);
        tick(); mem_resp_valid = 1'b1; mem_resp_data = 32'h13;
        if_req_valid = 1'b1; if_req_addr = 32'h104; #1;
        check("t1_resp_valid", 32'(if_resp_valid), 32'd1);
        check("t1_resp_data", if_resp_data, 32'h13);
        check("t1_busy_ready", 32'(if_req_ready), 32'd0);
        tick(); mem_resp_valid = 1'b0; #1;
        check("t1_resp_pulse", 32'(if_resp_valid), 32'd0);
        check("t1_next_accept", 32'(if_req_ready), 32'd1);
        finish_txn(32'h93);
        check("t1_resp2", if_resp_data, 32'h93);
        end_resp();

        // 2: contention, DM x4 then forced IF, then DM again after the counter clears
        for (int i = 0; i < 6; i++) begin
            if_req_valid = 1'b1; if_req_addr = 32'h400 + 32'(i * 4);
            dm_req_valid = 1'b1; dm_req_addr = 32'h3000; #1;
            exp_if = (i == 4);
            check("t2_if_ready", 32'(if_req_ready), 32'(exp_if));
            check("t2_dm_ready", 32'(dm_req_ready), 32'(!exp_if));
            finish_txn(32'h100 + 32'(i));
            check("t2_if_resp", 32'(if_resp_valid), 32'(exp_if));
            check("t2_dm_resp", 32'(dm_resp_valid), 32'(!exp_if));
            check("t2_data", exp_if ? if_resp_data : dm_resp_data, 32'h100 + 32'(i));
            end_resp();
        end

        // 3: store, registered request held while downstream stalls
        dm_req_valid = 1'b1; dm_req_addr = 32'h2000; dm_req_write = 1'b1;
        dm_req_wdata = 32'hCAFEBABE; dm_req_wstrb = 4'b0011; #1;
        check("t3_dm_ready", 32'(dm_req_ready), 32'd1);
        tick(); dm_req_valid = 1'b0; dm_req_write = 1'b0; dm_req_addr = '0;
        dm_req_wdata = '0; dm_req_wstrb = '0; #1;
        check("t3_req_valid", 32'(mem_req_valid), 32'd1);
        check("t3_req_addr", mem_req_addr, 32'h2000);
        check("t3_req_write", 32'(mem_req_write), 32'd1);
        check("t3_req_wdata", mem_req_wdata, 32'hCAFEBABE);
        check("t3_req_wstrb", 32'(mem_req_wstrb), 32'h3);
        tick(); #1;
        check("t3_hold_valid", 32'(mem_req_valid), 32'd1);
        check("t3_hold_wdata", mem_req_wdata, 32'hCAFEBABE);
        mem_req_ready = 1'b1;
        tick(); mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'h5A5A; #1;
        check("t3_dm_resp", 32'(dm_resp_valid), 32'd1);
        check("t3_if_resp", 32'(if_resp_valid), 32'd0);
        end_resp();
        check("t3_resp_pulse", 32'(dm_resp_valid), 32'd0);

        // 4: flush kills the pending fetch response
        if_req_valid = 1'b1; if_req_addr = 32'h200; flush = 1'b1; #1;
        check("t4_flush_block", 32'(if_req_ready), 32'd0);
        flush = 1'b0; #1;
        check("t4_accept", 32'(if_req_ready), 32'd1);
        tick(); if_req_valid = 1'b0; mem_req_ready = 1'b1;
        tick(); mem_req_ready = 1'b0; flush = 1'b1;
        tick(); flush = 1'b0;
        tick(); mem_resp_valid = 1'b1; mem_resp_data = 32'h55; if_req_valid = 1'b1; #1;
        check("t4_killed", 32'(if_resp_valid), 32'd0);
        check("t4_busy_ready", 32'(if_req_ready), 32'd0);
        tick(); mem_resp_valid = 1'b0; #1;
        check("t4_reaccept", 32'(if_req_ready), 32'd1);
        finish_txn(32'h77);
        check("t4_kill_cleared", 32'(if_resp_valid), 32'd1);
        check("t4_data", if_resp_data, 32'h77);
        end_resp();
        if_req_valid = 1'b1; #1;
        tick(); if_req_valid = 1'b0; mem_req_ready = 1'b1;
        tick(); mem_req_ready = 1'b0; mem_resp_valid = 1'b1; flush = 1'b1; #1;
        check("t4_same_cycle", 32'(if_resp_valid), 32'd0);
        tick(); mem_resp_valid = 1'b0; flush = 1'b0; #1;
        dm_req_valid = 1'b1; dm_req_addr = 32'h3004; #1;
        finish_txn(32'hABCD);
        flush = 1'b1; #1;
        check("t4_dm_unaffected", 32'(dm_resp_valid), 32'd1);
        check("t4_dm_data", dm_resp_data, 32'hABCD);
        flush = 1'b0;
        end_resp();

        // 5: async reset mid-issue
        if_req_valid = 1'b1; if_req_addr = 32'h300; #1;
        tick(); if_req_valid = 1'b0; #1;
        check("t5_issuing", 32'(mem_req_valid), 32'd1);
        reset_n = 1'b0; #1;
        check("t5_async_valid", 32'(mem_req_valid), 32'd0);
        check("t5_async_addr", mem_req_addr, 32'd0);
        tick(); tick(); reset_n = 1'b1; #1;
        check("t5_idle", 32'(mem_req_valid), 32'd0);
        if_req_valid = 1'b1; if_req_addr = 32'h100; #1;
        check("t5_accept", 32'(if_req_ready), 32'd1);
        finish_txn(32'h13);
        check("t5_resp", 32'(if_resp_valid), 32'd1);
        check("t5_data", if_resp_data, 32'h13);
        end_resp();

`ifdef UNIFIED_MEM_ARB_TIMEOUT_EN
        // 6: no response, timeout after 8 busy cycles
        check("t6_err_init", 32'(timeout_error), 32'd0);
        dm_req_valid = 1'b1; dm_req_addr = 32'h4000; #1;
        check("t6_accept", 32'(dm_req_ready), 32'd1);
        mem_req_ready = 1'b1;
        for (int k = 1; k < 8; k++) begin
            tick(); dm_req_valid = 1'b0; #1;
            check("t6_pending", 32'(dm_resp_valid), 32'd0);
            mem_req_ready = 1'b0;
        end
        tick(); #1;
        check("t6_resp", 32'(dm_resp_valid), 32'd1);
        check("t6_data", dm_resp_data, 32'd0);
        tick(); mem_resp_valid = 1'b1; mem_resp_data = 32'h99; #1;
        check("t6_err_set", 32'(timeout_error), 32'd1);
        check("t6_late_ignored", 32'(dm_resp_valid), 32'd0);
        mem_resp_valid = 1'b0;
        tick(); tick(); #1;
        check("t6_err_sticky", 32'(timeout_error), 32'd1);
        reset_n = 1'b0; #1;
        check("t6_err_reset", 32'(timeout_error), 32'd0);
        reset_n = 1'b1;
        tick();
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
